alu_mdu: RTL and testbench
==========================

// Module: alu_mdu
// PURPOSE
//  Parametrised-width integer ALU for the pipeline EX stage, with an iterative multiply/divide unit and HI/LO registers.
//  Single-cycle ops return a registered result one cycle after acceptance; mult/div occupy the unit for WIDTH cycles.
//  Adds signed SLT, signed-overflow detection, valid/ready handshake and a flush for EX-stage kills.
// PARAMETERS
//  WIDTH  32               datapath width in bits (>=8, power of 2)
//  SHW    $clog2(WIDTH)    shift-amount width, derived; not to be overridden
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operation presented on aluc/a/b
//  in_ready   out  1      unit can accept; transfer when in_valid & in_ready
//  aluc       in   5      opcode (ALU_* constants in alu_pkg)
//  a, b       in   WIDTH  operands; shifts: amount = a[SHW-1:0], value = b
//  flush      in   1      kill the in-flight or presented op
//  out_valid  out  1      one-cycle pulse: result/overflow valid
//  result     out  WIDTH  operation result
//  overflow   out  1      signed overflow for ADD/SUB, else 0
//  busy       out  1      mult/div iteration in progress
//  hi, lo     out  WIDTH  architectural HI/LO registers
// BEHAVIOUR
//  Reset: in_ready=1, out_valid=0, result=0, overflow=0, busy=0, hi=0, lo=0, counter=0, FSM=IDLE.
//  Opcodes:
//   0 ADD, 1 ADDU, 2 SUB, 3 SUBU, 4 AND, 5 OR, 6 XOR, 7 NOR, 8 SLT (signed), 9 SLTU, 10 SLL, 11 SRL, 12 SRA,
//   14 LUI ({b[WIDTH/2-1:0], zeros}), 15 MULT, 16 MULTU, 17 DIV, 18 DIVU, 19 MFHI, 20 MFLO, 21 MTHI, 22 MTLO.
//   Any other code: result=0, out_valid still pulses.
//  Arithmetic: all results wrap modulo 2^WIDTH. overflow=1 only for ADD/SUB on signed overflow; ADDU/SUBU never flag.
//  Single-cycle ops (0-14, 19-22): accept in cycle N -> out_valid=1 in N+1 with registered result.
//   MTHI/MTLO write hi/lo at N+1, return result=a. MFHI/MFLO return the current hi/lo.
//  FSM IDLE -> MUL or DIV when a mult/div op is accepted.
//   busy=1 and in_ready=0 while in MUL/DIV. Counter runs WIDTH-1 down to 0: one shift-add or restoring-subtract step per cycle.
//   Leaving MUL/DIV, in the cycle after the final step:
//    - FSM -> IDLE
//    - hi/lo written
//    - out_valid=1, result=new lo
//   Total latency: WIDTH+1 cycles from accept.
//  MULT/MULTU: {hi,lo} = 2*WIDTH-bit product. Signed: multiply magnitudes, negate if the operand signs differ.
//  DIV/DIVU: lo=quotient, hi=remainder. Quotient truncates toward zero; remainder takes the sign of a.
//   b==0: lo=all ones, hi=a, no trap.
//   Signed MIN/-1: lo=MIN, hi=0.
//  flush:
//   - with in_valid in IDLE: op not accepted
//   - in MUL/DIV: FSM -> IDLE next cycle, hi/lo unchanged, no out_valid
//   - in the completion cycle: hi/lo not written, out_valid suppressed
//  Back-to-back: IDLE with out_valid=1 still accepts a new op the same cycle. in_ready = FSM==IDLE.
//  rst asserted mid-iteration: immediate return to reset values; partial results discarded.
// CONFIGURATION
//  Macro ALU_MDU_DIV_EN:
//   - defined: DIV/DIVU implemented as above.
//   - undefined: divider logic omitted. DIV/DIVU complete as single-cycle ops with result=0, hi/lo unchanged, busy never set.
//  MULT/MTHI/MFHI etc. are unaffected either way.
// STRUCTURE
//  alu_pkg: ALU_* opcode localparams, FSM state encodings (IDLE/MUL/DIV), shared with the decoder.
//  Sub-module alu_mdu_iter: sign fix-up, iterative mul/div datapath, counter. Handshake: start/kind/done/abort.
//  alu_mdu keeps the combinational ALU, output registers, hi/lo and the handshake.
// TESTING
//  1. ADD a=32'h7FFF_FFFF b=1 -> next cycle result=32'h8000_0000, overflow=1. ADDU same operands -> overflow=0.
//  2. SLT a=32'hFFFF_FFFF b=1 -> result=1. SLTU same operands -> result=0. SRA a=4 b=32'h8000_0000 -> 32'hF800_0000.
//  3. MULT a=-3 b=7 -> busy 32 cycles, in_ready=0; at cycle 33 out_valid=1, hi=32'hFFFF_FFFF, lo=32'hFFFF_FFEB.
//     MFHI next -> 32'hFFFF_FFFF.
//  4. DIV a=-7 b=2 -> lo=-3, hi=-1. DIV a=5 b=0 -> lo=32'hFFFF_FFFF, hi=5.
//     DIV 32'h8000_0000 by -1 -> lo=32'h8000_0000, hi=0.
//  5. MULTU issued, flush at iteration 10 -> no out_valid, hi/lo keep prior values, in_ready=1 next cycle.
//  6. rst pulsed mid-DIVU -> all outputs 0 asynchronously. WIDTH=16 rerun of 3 -> latency 17, lo=16'hFFEB.

Source files
------------

// File: rtl/alu_mdu_pkg.sv
// Shared definitions for the EX-stage ALU and its iterative multiply/divide unit.
//   - ALU_* opcode constants (5-bit aluc encoding)
//   - MDU FSM state encoding (IDLE / MUL / DIV)
//   - iteration kind encoding for the alu_mdu_iter start handshake
//   - small decode helpers shared by the top level
package alu_mdu_pkg;

    localparam logic [4:0] ALU_ADD   = 5'd0;
    localparam logic [4:0] ALU_ADDU  = 5'd1;
    localparam logic [4:0] ALU_SUB   = 5'd2;
    localparam logic [4:0] ALU_SUBU  = 5'd3;
    localparam logic [4:0] ALU_AND   = 5'd4;
    localparam logic [4:0] ALU_OR    = 5'd5;
    localparam logic [4:0] ALU_XOR   = 5'd6;
    localparam logic [4:0] ALU_NOR   = 5'd7;
    localparam logic [4:0] ALU_SLT   = 5'd8;
    localparam logic [4:0] ALU_SLTU  = 5'd9;
    localparam logic [4:0] ALU_SLL   = 5'd10;
    localparam logic [4:0] ALU_SRL   = 5'd11;
    localparam logic [4:0] ALU_SRA   = 5'd12;
    localparam logic [4:0] ALU_LUI   = 5'd14;
    localparam logic [4:0] ALU_MULT  = 5'd15;
    localparam logic [4:0] ALU_MULTU = 5'd16;
    localparam logic [4:0] ALU_DIV   = 5'd17;
    localparam logic [4:0] ALU_DIVU  = 5'd18;
    localparam logic [4:0] ALU_MFHI  = 5'd19;
    localparam logic [4:0] ALU_MFLO  = 5'd20;
    localparam logic [4:0] ALU_MTHI  = 5'd21;
    localparam logic [4:0] ALU_MTLO  = 5'd22;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } mdu_state_e;

    localparam logic KIND_MUL = 1'b0;
    localparam logic KIND_DIV = 1'b1;

    function automatic logic is_mul_op(input logic [4:0] op);
        return (op == ALU_MULT) || (op == ALU_MULTU);
    endfunction

    function automatic logic is_div_op(input logic [4:0] op);
        return (op == ALU_DIV) || (op == ALU_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [4:0] op);
        return (op == ALU_MULT) || (op == ALU_DIV);
    endfunction

endpackage

// File: rtl/alu_mdu_iter.sv
// Iterative multiply/divide datapath with its sequencing FSM.
// Operands are converted to magnitudes at start; one shift-add (MUL) or
// restoring-subtract (DIV) step runs per cycle while the counter walks
// WIDTH-1 down to 0. On the final step the sign-corrected result is
// presented combinationally on hi_res/lo_res together with done.
// Divider datapath exists only when ALU_MDU_DIV_EN is defined.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   start, kind      launch request (kind: KIND_MUL / KIND_DIV)
//   is_signed        treat a/b as two's-complement
//   a, b             operands captured on launch
//   abort            drop the running operation, return to IDLE
//   idle, busy       FSM status (idle doubles as the top's in_ready)
//   done             final step this cycle and not aborted
//   hi_res, lo_res   result to commit when done
//
// state   | meaning
// --------+----------------------------------------------
// ST_IDLE | waiting for start
// ST_MUL  | shift-add multiply, one multiplier bit/cycle
// ST_DIV  | restoring divide, one quotient bit/cycle
module alu_mdu_iter
    import alu_mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             kind,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic             idle,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_res,
    output logic [WIDTH-1:0] lo_res
);

    localparam int SHW = $clog2(WIDTH);

    mdu_state_e state, state_next;

    logic [SHW-1:0]       cnt;
    // upper half: partial product / partial remainder; lower half: multiplier / quotient
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     opb;
    logic                 neg_lo;
    logic                 launch;
    logic                 last;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_step;
    logic [2*WIDTH-1:0]   acc_step;
    logic [2*WIDTH-1:0]   prod;

`ifdef ALU_MDU_DIV_EN
    logic                 neg_hi;
    logic                 b_zero;
    logic [WIDTH-1:0]     a_hold;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH-1:0]     div_diff;
    logic                 div_fits;
    logic [2*WIDTH-1:0]   div_step;
    logic [WIDTH-1:0]     quo, rem;

    assign launch = start;
`else
    assign launch = start && (kind == KIND_MUL);
`endif

    assign last  = (cnt == '0);
    assign mag_a = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign mag_b = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;

    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opb : {WIDTH{1'b0}})};
    assign mul_step = {mul_sum, acc[WIDTH-1:1]};

`ifdef ALU_MDU_DIV_EN
    assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_fits  = (div_shift >= {1'b0, opb});
    // when it fits the difference is below opb, so WIDTH bits suffice
    assign div_diff  = div_shift[WIDTH-1:0] - opb;
    assign div_step  = div_fits ? {div_diff, acc[WIDTH-2:0], 1'b1}
                                : {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    assign acc_step  = (state == ST_DIV) ? div_step : mul_step;
    assign quo       = acc_step[WIDTH-1:0];
    assign rem       = acc_step[2*WIDTH-1:WIDTH];
`else
    assign acc_step  = mul_step;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
`ifdef ALU_MDU_DIV_EN
                if (launch) state_next = (kind == KIND_DIV) ? ST_DIV : ST_MUL;
`else
                if (launch) state_next = ST_MUL;
`endif
            end
            ST_MUL, ST_DIV: begin
                if (abort || last) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        idle = (state == ST_IDLE);
        busy = (state != ST_IDLE);
        done = (state != ST_IDLE) && last && !abort;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            acc    <= '0;
            opb    <= '0;
            neg_lo <= 1'b0;
`ifdef ALU_MDU_DIV_EN
            neg_hi <= 1'b0;
            b_zero <= 1'b0;
            a_hold <= '0;
`endif
        end else if (state == ST_IDLE) begin
            if (launch) begin
                cnt    <= SHW'(WIDTH - 1);
                acc    <= {{WIDTH{1'b0}}, mag_a};
                opb    <= mag_b;
                neg_lo <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef ALU_MDU_DIV_EN
                neg_hi <= is_signed && a[WIDTH-1];
                b_zero <= (b == '0);
                a_hold <= a;
`endif
            end
        end else if (abort) begin
            cnt <= '0;
        end else begin
            acc <= acc_step;
            if (!last) cnt <= cnt - 1'b1;
        end
    end

    always_comb begin
        prod   = neg_lo ? (~acc_step + 1'b1) : acc_step;
        hi_res = prod[2*WIDTH-1:WIDTH];
        lo_res = prod[WIDTH-1:0];
`ifdef ALU_MDU_DIV_EN
        if (state == ST_DIV) begin
            if (b_zero) begin
                // divide by zero: all-ones quotient, dividend as remainder
                lo_res = '1;
                hi_res = a_hold;
            end else begin
                lo_res = neg_lo ? (~quo + 1'b1) : quo;
                hi_res = neg_hi ? (~rem + 1'b1) : rem;
            end
        end
`endif
    end

endmodule

// File: rtl/alu_mdu.sv
// EX-stage integer ALU with HI/LO registers and an iterative MUL/DIV unit.
// Single-cycle ops register their result one cycle after acceptance;
// MULT/MULTU (and DIV/DIVU when enabled) hold the unit for WIDTH cycles
// and complete WIDTH+1 cycles after acceptance.
// Optional feature macro: ALU_MDU_DIV_EN (iterative divider). Without it
// DIV/DIVU complete in one cycle with result 0 and HI/LO untouched.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   in_valid/in_ready handshake for aluc/a/b
//   aluc              opcode (ALU_* in alu_mdu_pkg)
//   a, b              operands; shifts use a[SHW-1:0] as amount on b
//   flush             kill the presented or in-flight operation
//   out_valid         one-cycle pulse qualifying result/overflow
//   result, overflow  registered result, signed ADD/SUB overflow
//   busy              multiply/divide iteration in progress
//   hi, lo            architectural HI/LO registers
module alu_mdu
    import alu_mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       aluc,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int SHW = $clog2(WIDTH);

    logic             accept;
    logic             mdu_op;
    logic             mdu_kind;
    logic             mdu_start;
    logic             single_fire;
    logic             mdu_idle;
    logic             mdu_done;
    logic [WIDTH-1:0] mdu_hi, mdu_lo;
    logic [WIDTH-1:0] sum, diff;
    logic [SHW-1:0]   shamt;
    logic             add_ovf, sub_ovf, slt, sltu;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;

    assign in_ready = mdu_idle;
    assign accept   = in_valid && in_ready && !flush;

`ifdef ALU_MDU_DIV_EN
    assign mdu_op   = is_mul_op(aluc) || is_div_op(aluc);
    assign mdu_kind = is_div_op(aluc) ? KIND_DIV : KIND_MUL;
`else
    assign mdu_op   = is_mul_op(aluc);
    assign mdu_kind = KIND_MUL;
`endif

    assign mdu_start   = accept && mdu_op;
    assign single_fire = accept && !mdu_op;

    alu_mdu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk       (clk),
        .rst       (rst),
        .start     (mdu_start),
        .kind      (mdu_kind),
        .is_signed (is_signed_op(aluc)),
        .a         (a),
        .b         (b),
        .abort     (flush),
        .idle      (mdu_idle),
        .busy      (busy),
        .done      (mdu_done),
        .hi_res    (mdu_hi),
        .lo_res    (mdu_lo)
    );

    assign sum     = a + b;
    assign diff    = a - b;
    assign shamt   = a[SHW-1:0];
    // signed overflow: result sign disagrees with what the operand signs force
    assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1]  != a[WIDTH-1]);
    assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    assign slt     = ($signed(a) < $signed(b));
    assign sltu    = (a < b);

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (aluc)
            ALU_ADD:  begin alu_res = sum;  alu_ovf = add_ovf; end
            ALU_ADDU: alu_res = sum;
            ALU_SUB:  begin alu_res = diff; alu_ovf = sub_ovf; end
            ALU_SUBU: alu_res = diff;
            ALU_AND:  alu_res = a & b;
            ALU_OR:   alu_res = a | b;
            ALU_XOR:  alu_res = a ^ b;
            ALU_NOR:  alu_res = ~(a | b);
            ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt};
            ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, sltu};
            ALU_SLL:  alu_res = b << shamt;
            ALU_SRL:  alu_res = b >> shamt;
            ALU_SRA:  alu_res = $signed(b) >>> shamt;
            ALU_LUI:  alu_res = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            ALU_MFHI: alu_res = hi;
            ALU_MFLO: alu_res = lo;
            ALU_MTHI: alu_res = a;
            ALU_MTLO: alu_res = a;
            default:  alu_res = '0;
        endcase
    end

    // mdu_done and single_fire are exclusive: accept needs the unit idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            out_valid <= 1'b0;
            if (mdu_done) begin
                out_valid <= 1'b1;
                result    <= mdu_lo;
                overflow  <= 1'b0;
                hi        <= mdu_hi;
                lo        <= mdu_lo;
            end else if (single_fire) begin
                out_valid <= 1'b1;
                result    <= alu_res;
                overflow  <= alu_ovf;
                if (aluc == ALU_MTHI) hi <= a;
                if (aluc == ALU_MTLO) lo <= a;
            end
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu: directed vector table, hand-written
// multi-cycle / flush / reset sequences, randomized ops against a
// behavioural model, and a WIDTH=16 instance for the latency check.
module tb_alu_mdu;
    import alu_mdu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, flush, in_ready, out_valid, overflow, busy;
    logic [4:0]  aluc;
    logic [31:0] a, b, result, hi, lo;

    logic        in_valid16, flush16, in_ready16, out_valid16, overflow16, busy16;
    logic [4:0]  aluc16;
    logic [15:0] a16, b16, result16, hi16, lo16;

    alu_mdu #(.WIDTH(32)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .aluc(aluc), .a(a), .b(b), .flush(flush), .out_valid(out_valid),
        .result(result), .overflow(overflow), .busy(busy), .hi(hi), .lo(lo)
    );

    alu_mdu #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .aluc(aluc16), .a(a16), .b(b16), .flush(flush16), .out_valid(out_valid16),
        .result(result16), .overflow(overflow16), .busy(busy16), .hi(hi16), .lo(lo16)
    );

    int tests = 0;
    int fails = 0;
    logic [31:0] mh = '0, ml = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Architectural reference: plain integer arithmetic on 64-bit values.
    function automatic void model(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                                  inout logic [31:0] h, inout logic [31:0] l,
                                  output logic [31:0] r, output logic v, output int lat);
        longint sx, sy, s;
        longint maxv, minv;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        maxv = 64'sh7FFF_FFFF;
        minv = -maxv - 1;
        r = '0; v = 1'b0; lat = 1;
        case (op)
            ALU_ADD:  begin s = sx + sy; r = s[31:0]; v = (s > maxv) || (s < minv); end
            ALU_ADDU: r = x + y;
            ALU_SUB:  begin s = sx - sy; r = s[31:0]; v = (s > maxv) || (s < minv); end
            ALU_SUBU: r = x - y;
            ALU_AND:  r = x & y;
            ALU_OR:   r = x | y;
            ALU_XOR:  r = x ^ y;
            ALU_NOR:  r = ~(x | y);
            ALU_SLT:  r = (sx < sy) ? 32'd1 : 32'd0;
            ALU_SLTU: r = (x < y) ? 32'd1 : 32'd0;
            ALU_SLL:  r = y << x[4:0];
            ALU_SRL:  r = y >> x[4:0];
            ALU_SRA:  r = 32'($signed(y) >>> x[4:0]);
            ALU_LUI:  r = {y[15:0], 16'h0000};
            ALU_MULT: begin p = 64'(sx * sy); h = p[63:32]; l = p[31:0]; r = l; lat = 33; end
            ALU_MULTU: begin p = {32'h0, x} * {32'h0, y}; h = p[63:32]; l = p[31:0]; r = l; lat = 33; end
`ifdef ALU_MDU_DIV_EN
            ALU_DIV: begin
                if (y == 32'h0) begin l = '1; h = x; end
                else begin s = sx / sy; l = s[31:0]; s = sx % sy; h = s[31:0]; end
                r = l; lat = 33;
            end
            ALU_DIVU: begin
                if (y == 32'h0) begin l = '1; h = x; end
                else begin l = x / y; h = x % y; end
                r = l; lat = 33;
            end
`endif
            ALU_MFHI: r = h;
            ALU_MFLO: r = l;
            ALU_MTHI: begin h = x; r = x; end
            ALU_MTLO: begin l = x; r = x; end
            default:  r = '0;
        endcase
    endfunction

    // Present one op, wait (bounded) for out_valid; lat counts edges from accept.
    task automatic run_op(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] r, output logic v, output int lat,
                          output logic got, output logic busy_ok);
        @(negedge clk);
        in_valid = 1'b1; aluc = op; a = x; b = y;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        busy_ok = 1'b1;
        while (!out_valid && lat < 200) begin
            if (!busy || in_ready) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        got = out_valid; r = result; v = overflow;
    endtask

    task automatic check_model(input string tag, input logic [4:0] op,
                               input logic [31:0] x, input logic [31:0] y);
        logic [31:0] er, r;
        logic ev, v, got, bok;
        int el, lat;
        model(op, x, y, mh, ml, er, ev, el);
        run_op(op, x, y, r, v, lat, got, bok);
        chk({tag, "_valid"}, 64'(got), 64'(1'b1));
        chk({tag, "_res"}, 64'(r), 64'(er));
        chk({tag, "_ovf"}, 64'(v), 64'(ev));
        chk({tag, "_lat"}, 64'(lat), 64'(el));
        chk({tag, "_hi"}, 64'(hi), 64'(mh));
        chk({tag, "_lo"}, 64'(lo), 64'(ml));
        chk({tag, "_busy"}, 64'(bok), 64'(1'b1));
    endtask

    // Flush k edges after the accept edge; op must vanish without trace.
    task automatic flush_mid(input string tag, input logic [4:0] op, input int k);
        logic seen;
        @(negedge clk);
        in_valid = 1'b1; aluc = op; a = 32'h1234_5678; b = 32'h0000_0FED;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (k) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk({tag, "_ov"}, 64'(out_valid), 64'(1'b0));
        chk({tag, "_ready"}, 64'(in_ready), 64'(1'b1));
        chk({tag, "_busy"}, 64'(busy), 64'(1'b0));
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk({tag, "_late_ov"}, 64'(seen), 64'(1'b0));
        chk({tag, "_hi"}, 64'(hi), 64'(mh));
        chk({tag, "_lo"}, 64'(lo), 64'(ml));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    typedef struct {
        logic [4:0]  op;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] res;
        logic        ovf;
    } vec_t;

    vec_t vt[$];

    initial begin
        logic [31:0] r;
        logic v, got, bok;
        int lat;

        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; aluc = '0; a = '0; b = '0;
        in_valid16 = 1'b0; flush16 = 1'b0; aluc16 = '0; a16 = '0; b16 = '0;

        vt.push_back('{ALU_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1});
        vt.push_back('{ALU_ADDU, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0});
        vt.push_back('{ALU_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0});
        vt.push_back('{ALU_ADD,  32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1});
        vt.push_back('{ALU_SUB,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1});
        vt.push_back('{ALU_SUBU, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0});
        vt.push_back('{ALU_SUB,  32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0});
        vt.push_back('{ALU_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0});
        vt.push_back('{ALU_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0});
        vt.push_back('{ALU_SRA,  32'h0000_0004, 32'h8000_0000, 32'hF800_0000, 1'b0});
        vt.push_back('{ALU_SRL,  32'h0000_0004, 32'h8000_0000, 32'h0800_0000, 1'b0});
        vt.push_back('{ALU_SLL,  32'h0000_003F, 32'h0000_0003, 32'h8000_0000, 1'b0});
        vt.push_back('{ALU_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0});
        vt.push_back('{ALU_OR,   32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0});
        vt.push_back('{ALU_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0});
        vt.push_back('{ALU_NOR,  32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0});
        vt.push_back('{ALU_LUI,  32'h0000_0000, 32'h0000_ABCD, 32'hABCD_0000, 1'b0});
        vt.push_back('{5'd13,    32'h0000_0001, 32'h0000_0002, 32'h0000_0000, 1'b0});
        vt.push_back('{5'd31,    32'h0000_0001, 32'h0000_0002, 32'h0000_0000, 1'b0});

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 64'(in_ready), 64'(1'b1));
        chk("rst_ov", 64'(out_valid), 64'(1'b0));
        chk("rst_res", 64'(result), 64'h0);
        chk("rst_ovf", 64'(overflow), 64'(1'b0));
        chk("rst_busy", 64'(busy), 64'(1'b0));
        chk("rst_hi", 64'(hi), 64'h0);
        chk("rst_lo", 64'(lo), 64'h0);
        chk("rst16_ready", 64'(in_ready16), 64'(1'b1));
        @(negedge clk);
        rst = 1'b0;

        // directed vector table
        foreach (vt[i]) begin
            run_op(vt[i].op, vt[i].x, vt[i].y, r, v, lat, got, bok);
            chk($sformatf("vec%0d_valid", i), 64'(got), 64'(1'b1));
            chk($sformatf("vec%0d_res", i), 64'(r), 64'(vt[i].res));
            chk($sformatf("vec%0d_ovf", i), 64'(v), 64'(vt[i].ovf));
            chk($sformatf("vec%0d_lat", i), 64'(lat), 64'd1);
        end

        // MULT -3 * 7, then back-to-back MFHI while out_valid is high
        run_op(ALU_MULT, 32'hFFFF_FFFD, 32'h0000_0007, r, v, lat, got, bok);
        chk("mult_lat", 64'(lat), 64'd33);
        chk("mult_busy", 64'(bok), 64'(1'b1));
        chk("mult_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("mult_lo", 64'(lo), 64'hFFFF_FFEB);
        chk("mult_res", 64'(r), 64'hFFFF_FFEB);
        chk("b2b_ready", 64'(in_ready), 64'(1'b1));
        mh = 32'hFFFF_FFFF; ml = 32'hFFFF_FFEB;
        run_op(ALU_MFHI, 32'h0, 32'h0, r, v, lat, got, bok);
        chk("mfhi_res", 64'(r), 64'hFFFF_FFFF);
        chk("mfhi_lat", 64'(lat), 64'd1);

`ifdef ALU_MDU_DIV_EN
        run_op(ALU_DIV, 32'hFFFF_FFF9, 32'h0000_0002, r, v, lat, got, bok);
        chk("div_lo", 64'(lo), 64'hFFFF_FFFD);
        chk("div_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("div_lat", 64'(lat), 64'd33);
        run_op(ALU_DIV, 32'h0000_0005, 32'h0000_0000, r, v, lat, got, bok);
        chk("div0_lo", 64'(lo), 64'hFFFF_FFFF);
        chk("div0_hi", 64'(hi), 64'h5);
        run_op(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, r, v, lat, got, bok);
        chk("divmin_lo", 64'(lo), 64'h8000_0000);
        chk("divmin_hi", 64'(hi), 64'h0);
        mh = 32'h0; ml = 32'h8000_0000;
`else
        run_op(ALU_DIV, 32'h0000_0005, 32'h0000_0000, r, v, lat, got, bok);
        chk("div_off_res", 64'(r), 64'h0);
        chk("div_off_lat", 64'(lat), 64'd1);
        chk("div_off_hi", 64'(hi), 64'(mh));
        chk("div_off_lo", 64'(lo), 64'(ml));
`endif

        // flush with in_valid in IDLE: op must not be accepted
        @(negedge clk);
        in_valid = 1'b1; flush = 1'b1; aluc = ALU_MTHI; a = 32'hDEAD_BEEF; b = '0;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_idle_ov", 64'(out_valid), 64'(1'b0));
        chk("flush_idle_hi", 64'(hi), 64'(mh));
        chk("flush_idle_busy", 64'(busy), 64'(1'b0));

        flush_mid("flush_it10", ALU_MULTU, 9);
        flush_mid("flush_last", ALU_MULT, 31);

        // randomized ops against the model
        for (int n = 0; n < 80; n++) begin
            logic [4:0] op;
            op = 5'($urandom_range(0, 24));
            check_model($sformatf("rnd%0d_op%0d", n, op), op, pick(), pick());
        end

        // async reset mid-iteration
        check_model("pre_rst_mthi", ALU_MTHI, 32'h0000_0055, 32'h0);
        @(negedge clk);
        in_valid = 1'b1; a = 32'h0000_1234; b = 32'h0000_0011;
`ifdef ALU_MDU_DIV_EN
        aluc = ALU_DIVU;
`else
        aluc = ALU_MULTU;
`endif
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_ready", 64'(in_ready), 64'(1'b1));
        chk("arst_busy", 64'(busy), 64'(1'b0));
        chk("arst_ov", 64'(out_valid), 64'(1'b0));
        chk("arst_res", 64'(result), 64'h0);
        chk("arst_hi", 64'(hi), 64'h0);
        chk("arst_lo", 64'(lo), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        mh = '0; ml = '0;

        // WIDTH=16 MULT -3 * 7: latency 17
        @(negedge clk);
        in_valid16 = 1'b1; aluc16 = ALU_MULT; a16 = 16'hFFFD; b16 = 16'h0007;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        lat = 1;
        while (!out_valid16 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("w16_lat", 64'(lat), 64'd17);
        chk("w16_lo", 64'(lo16), 64'hFFEB);
        chk("w16_hi", 64'(hi16), 64'hFFFF);
        chk("w16_res", 64'(result16), 64'hFFEB);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
